euler_row_scheduler: RTL
========================

Name: euler_row_scheduler

Overview:
Sequencing controller for the Euler matrix-vector MAC pipeline.
- Configures the pipeline shape.
- Issues one row pass at a time and collects each row's accumulated result.
- Writes each result into the state/result memory.
- Repeats for a programmed number of Euler time steps, then raises the pipeline's final-done.
- Sits between the top-level ODE controller and the pipeline.

Parameters:
ADD_SIZE, 16, result-memory address width
DATA_SIZE, 16, accumulator/result data width
MAX_DIM, 6, width of row/column counts (max dimension 2^MAX_DIM-1)
STEP_W, 16, width of the time-step counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a run when idle
cfg_rows  input  MAX_DIM  number of matrix rows (vector outputs)
cfg_cols  input  MAX_DIM  number of matrix columns
cfg_steps  input  STEP_W  number of Euler steps
cfg_base  input  ADD_SIZE  result memory base address
pipe_start  output  1  one-cycle pulse starting one row pass
pipe_return_default  output  1  one-cycle pulse; clears pipeline accumulator after a row is captured
pipe_final_done  output  1  held high in DONE; tells the pipeline the run is finished
shape_rows  output  MAX_DIM  latched cfg_rows
shape_cols  output  MAX_DIM  latched cfg_cols
pipe_data_ready  input  1  pipeline row result valid (level)
pipe_out_acc  input  DATA_SIZE  pipeline row result
pipe_overflow  input  1  pipeline overflow flag
res_wr_en  output  1  result write strobe
res_wr_addr  output  ADD_SIZE  result write address
res_wr_data  output  DATA_SIZE  result write data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on run completion
error  output  1  sticky; set on overflow or bad config, cleared only by rst or an accepted start

Behaviour:
- Reset: state IDLE. All outputs 0, except shape_rows and shape_cols, which hold 0 until the first CONFIG. Counters are 0.
- IDLE:
  - start=1 → CONFIG, and clear error.
  - start is ignored in every other state.
- CONFIG (1 cycle):
  - Latch cfg_rows, cfg_cols, cfg_steps and cfg_base into the shape/registers.
  - Set row=0, step=0.
  - If cfg_rows==0, cfg_cols==0 or cfg_steps==0 → ERR; otherwise → ISSUE.
- ISSUE (1 cycle): pipe_start=1, then → WAIT_ROW.
- WAIT_ROW:
  - Hold until pipe_data_ready=1, then → WRITE.
  - pipe_overflow=1 in any busy state → ERR (overflow takes priority over data_ready in the same cycle).
- WRITE (1 cycle):
  - res_wr_en=1.
  - res_wr_addr = cfg_base + step*rows + row; the address is kept in a running register, incremented by 1 per write, modulo 2^ADD_SIZE (wraps silently).
  - res_wr_data = pipe_out_acc as sampled in the WRITE cycle.
  - pipe_return_default=1 in the same cycle.
  - Then:
    - If row==rows-1 → NEXT_STEP.
    - Else row++ → ISSUE.
- NEXT_STEP (1 cycle):
  - row=0, step++.
  - If the incremented step==steps → DONE; otherwise → ISSUE.
- DONE:
  - pipe_final_done=1 and done=1 for exactly one cycle, then → IDLE.
  - pipe_final_done drops when IDLE is entered.
- ERR:
  - error=1, pipe_final_done=1 for one cycle, then → IDLE.
  - error stays set.
- Latency:
  - start to first pipe_start is 2 cycles (CONFIG, then ISSUE).
  - Each row costs 3 cycles plus the pipeline's row latency.
- rst asserted mid-run returns to IDLE on the next edge regardless of state; no write occurs in that cycle.
- pipe_data_ready outside WAIT_ROW is ignored.

Optional Feature:
Macro: EULER_SCHED_WATCHDOG_EN.
- Defined:
  - A 12-bit watchdog counts cycles in WAIT_ROW and clears on leaving it.
  - Reaching 4095 forces → ERR and sets output wd_timeout (extra 1-bit port, sticky like error).
- Not defined: no counter and no wd_timeout port; WAIT_ROW waits indefinitely.

Test Plan:
1. rows=2, cols=2, steps=1, base=0x10; pipeline model returns 5 then 7 → writes (0x10,5), (0x11,7); done pulses once; pipe_start pulses 2 times.
2. rows=3, cols=3, steps=2, base=0 → 6 writes at addresses 0..5 in order; pipe_return_default pulses 6 times; busy falls the cycle after done.
3. cfg_rows=0 → CONFIG→ERR; error=1; no pipe_start and no res_wr_en.
4. pipe_overflow asserted during the 2nd row's WAIT_ROW → ERR with no write for that row; error stays 1 until the next start, which clears it.
5. rst asserted in WAIT_ROW of step 1 → next cycle IDLE with all outputs 0; a fresh start runs normally.
6. base=0xFFFF, rows=2, steps=1 → writes at 0xFFFF then 0x0000 (wrap). With EULER_SCHED_WATCHDOG_EN and data_ready never asserted → wd_timeout=1 after 4095 cycles in WAIT_ROW.

Source files
------------

// File: rtl/euler_row_scheduler_if.sv
// Pipeline and result-memory bus between euler_row_scheduler and the
// Euler matrix-vector MAC pipeline / state memory.
// master: the scheduler side; slave: the pipeline/memory side.
interface euler_row_scheduler_if #(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16,
  parameter int MAX_DIM   = 6
);
  logic                        pipe_start;
  logic                        pipe_return_default;
  logic                        pipe_final_done;
  logic        [MAX_DIM-1:0]   shape_rows;
  logic        [MAX_DIM-1:0]   shape_cols;
  logic                        pipe_data_ready;
  logic signed [DATA_SIZE-1:0] pipe_out_acc;
  logic                        pipe_overflow;
  logic                        res_wr_en;
  logic        [ADD_SIZE-1:0]  res_wr_addr;
  logic signed [DATA_SIZE-1:0] res_wr_data;

  modport master (
    output pipe_start, pipe_return_default, pipe_final_done,
    output shape_rows, shape_cols,
    input  pipe_data_ready, pipe_out_acc, pipe_overflow,
    output res_wr_en, res_wr_addr, res_wr_data
  );

  modport slave (
    input  pipe_start, pipe_return_default, pipe_final_done,
    input  shape_rows, shape_cols,
    output pipe_data_ready, pipe_out_acc, pipe_overflow,
    input  res_wr_en, res_wr_addr, res_wr_data
  );
endinterface

// File: rtl/euler_row_scheduler.sv
// Row-pass sequencer for the Euler MAC pipeline: issues one row at a time,
// writes each row result to the state/result memory at a running address,
// repeats for the programmed number of time steps, then signals final-done.
// Optional macro EULER_SCHED_WATCHDOG_EN adds a 12-bit WAIT_ROW watchdog and
// the sticky o_wd_timeout output.
module euler_row_scheduler #(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16,
  parameter int MAX_DIM   = 6,
  parameter int STEP_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [MAX_DIM-1:0]  i_cfg_rows,
  input  logic [MAX_DIM-1:0]  i_cfg_cols,
  input  logic [STEP_W-1:0]   i_cfg_steps,
  input  logic [ADD_SIZE-1:0] i_cfg_base,
  euler_row_scheduler_if.master bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error
`ifdef EULER_SCHED_WATCHDOG_EN
  ,
  output logic                o_wd_timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_ISSUE, S_WAIT_ROW,
    S_WRITE, S_NEXT_STEP, S_DONE, S_ERR
  } state_t;

  state_t              r_state;
  logic [MAX_DIM-1:0]  r_rows;
  logic [MAX_DIM-1:0]  r_cols;
  logic [MAX_DIM-1:0]  r_row;
  logic [STEP_W-1:0]   r_steps;
  logic [STEP_W-1:0]   r_step;
  logic [ADD_SIZE-1:0] r_addr;
  logic [ADD_SIZE-1:0] r_wr_addr;
  logic                r_pipe_start;
  logic                r_ret_default;
  logic                r_final_done;
  logic                r_wr_en;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
`ifdef EULER_SCHED_WATCHDOG_EN
  logic [11:0]         r_wd;
  logic                r_wd_timeout;
`endif

  logic                w_ovf;
  logic                w_cfg_bad;
  logic                w_last_row;
  logic [STEP_W-1:0]   w_step_inc;
  logic                w_wr_live;

  // Overflow aborts from any busy state except ERR, which is already leaving.
  assign w_ovf      = bus.pipe_overflow && (r_state != S_IDLE) && (r_state != S_ERR);
  assign w_cfg_bad  = (i_cfg_rows == '0) || (i_cfg_cols == '0) || (i_cfg_steps == '0);
  assign w_last_row = (r_row == r_rows - MAX_DIM'(1));
  assign w_step_inc = r_step + STEP_W'(1);
  // A write in the same cycle as rst is suppressed; data is passed straight
  // through so the memory captures the accumulator as it stands in WRITE.
  assign w_wr_live  = r_wr_en && !rst;

  assign bus.pipe_start          = r_pipe_start;
  assign bus.pipe_return_default = r_ret_default;
  assign bus.pipe_final_done     = r_final_done;
  assign bus.shape_rows          = r_rows;
  assign bus.shape_cols          = r_cols;
  assign bus.res_wr_en           = w_wr_live;
  assign bus.res_wr_addr         = r_wr_addr;
  assign bus.res_wr_data         = w_wr_live ? bus.pipe_out_acc : '0;
  assign o_busy                  = r_busy;
  assign o_done                  = r_done;
  assign o_error                 = r_error;
`ifdef EULER_SCHED_WATCHDOG_EN
  assign o_wd_timeout            = r_wd_timeout;
`endif

  // Sequencer FSM; every output is registered on entry to the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rows        <= '0;
      r_cols        <= '0;
      r_row         <= '0;
      r_steps       <= '0;
      r_step        <= '0;
      r_addr        <= '0;
      r_wr_addr     <= '0;
      r_pipe_start  <= 1'b0;
      r_ret_default <= 1'b0;
      r_final_done  <= 1'b0;
      r_wr_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
`ifdef EULER_SCHED_WATCHDOG_EN
      r_wd          <= '0;
      r_wd_timeout  <= 1'b0;
`endif
    end else begin
      r_pipe_start  <= 1'b0;
      r_ret_default <= 1'b0;
      r_final_done  <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_done        <= 1'b0;
      if (w_ovf) begin
        r_state      <= S_ERR;
        r_error      <= 1'b1;
        r_final_done <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state <= S_CONFIG;
              r_busy  <= 1'b1;
              r_error <= 1'b0;
`ifdef EULER_SCHED_WATCHDOG_EN
              r_wd_timeout <= 1'b0;
`endif
            end
          end
          S_CONFIG: begin
            r_rows  <= i_cfg_rows;
            r_cols  <= i_cfg_cols;
            r_steps <= i_cfg_steps;
            r_addr  <= i_cfg_base;
            r_row   <= '0;
            r_step  <= '0;
            if (w_cfg_bad) begin
              r_state      <= S_ERR;
              r_error      <= 1'b1;
              r_final_done <= 1'b1;
            end else begin
              r_state      <= S_ISSUE;
              r_pipe_start <= 1'b1;
            end
          end
          S_ISSUE: begin
            r_state <= S_WAIT_ROW;
`ifdef EULER_SCHED_WATCHDOG_EN
            r_wd    <= '0;
`endif
          end
          S_WAIT_ROW: begin
            if (bus.pipe_data_ready) begin
              r_state       <= S_WRITE;
              r_wr_en       <= 1'b1;
              r_wr_addr     <= r_addr;
              r_ret_default <= 1'b1;
            end
`ifdef EULER_SCHED_WATCHDOG_EN
            // 4095 cycles spent waiting (counter values 0..4094) is a hang.
            else if (r_wd == 12'hFFE) begin
              r_state      <= S_ERR;
              r_error      <= 1'b1;
              r_final_done <= 1'b1;
              r_wd_timeout <= 1'b1;
            end else begin
              r_wd <= r_wd + 12'd1;
            end
`endif
          end
          S_WRITE: begin
            r_addr <= r_addr + ADD_SIZE'(1);
            if (w_last_row) begin
              r_state <= S_NEXT_STEP;
            end else begin
              r_row        <= r_row + MAX_DIM'(1);
              r_state      <= S_ISSUE;
              r_pipe_start <= 1'b1;
            end
          end
          S_NEXT_STEP: begin
            r_row  <= '0;
            r_step <= w_step_inc;
            if (w_step_inc == r_steps) begin
              r_state      <= S_DONE;
              r_final_done <= 1'b1;
              r_done       <= 1'b1;
            end else begin
              r_state      <= S_ISSUE;
              r_pipe_start <= 1'b1;
            end
          end
          S_DONE, S_ERR: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
